// File: rtl/approx_compressor_8_2_pipe.sv
// Two-stage valid/ready pipeline of LANES 8:2 compressors, exact or approximate per beat.
// Saturating error/sample statistics are collected on delivery of approximate beats.
module approx_compressor_8_2_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*LANES-1:0] out_data,
    output logic               out_mode,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   sample_cnt
);
    localparam int IW = $clog2(LANES + 1);
    localparam int SW = CNT_W + IW;

    logic               s1_valid_q, s1_mode_q;
    logic [8*LANES-1:0] s1_data_q;
    logic               s2_valid_q, s2_mode_q;
    logic [4*LANES-1:0] s2_data_q;
    logic [IW-1:0]      s2_nerr_q;
    logic [CNT_W-1:0]   err_q, samp_q;

    logic [4*LANES-1:0] res_d;
    logic [IW-1:0]      nerr_d;
    logic               s1_adv, s2_adv, accept, xfer_approx;

    // approx_full_adder_v1: returns {cout, sum}; carry only on a&b, cin forces sum
    function automatic logic [1:0] afa(input logic a, input logic b, input logic c);
        afa = {a & b, (a ^ b) | c};
    endfunction

    function automatic logic [3:0] popcnt(input logic [7:0] d);
        popcnt = '0;
        for (int i = 0; i < 8; i++) popcnt = popcnt + {3'b000, d[i]};
    endfunction

    function automatic logic [3:0] approx_tree(input logic [7:0] d);
        logic [1:0] f1a, f1b, f1c, f2s, f2c, f3;
        f1a = afa(d[0], d[1], d[2]);
        f1b = afa(d[3], d[4], d[5]);
        f1c = afa(d[6], d[7], 1'b0);
        f2s = afa(f1a[0], f1b[0], f1c[0]);
        f2c = afa(f1a[1], f1b[1], f1c[1]);
        f3  = afa(f2c[0], f2s[1], 1'b0);
        approx_tree = {2'b00, f3[0], f2s[0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [IW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s[SW-1:CNT_W] != '0) sat_add = '1;
        else sat_add = s[CNT_W-1:0];
    endfunction

    assign s2_adv      = !s2_valid_q || out_ready;
    assign s1_adv      = s2_adv || !s1_valid_q;
    assign in_ready    = !rst && s1_adv;
    assign accept      = in_valid && in_ready;
    assign xfer_approx = s2_valid_q && out_ready && s2_mode_q;

    always_comb begin
        res_d  = '0;
        nerr_d = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [3:0] ex, ap;
            ex = popcnt(s1_data_q[8*k +: 8]);
            ap = approx_tree(s1_data_q[8*k +: 8]);
            res_d[4*k +: 4] = s1_mode_q ? ap : ex;
            if (ap != ex) nerr_d = nerr_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_mode_q <= in_mode;
                s1_data_q <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_data_q  <= '0;
            s2_nerr_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_q <= s1_mode_q;
                s2_data_q <= res_d;
                s2_nerr_q <= nerr_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= '0;
            samp_q <= '0;
        end else if (clr_stats) begin
            err_q  <= '0;
            samp_q <= '0;
        end else if (xfer_approx) begin
            err_q  <= sat_add(err_q, s2_nerr_q);
            samp_q <= sat_add(samp_q, IW'(LANES));
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_mode   = s2_mode_q;
    assign err_cnt    = err_q;
    assign sample_cnt = samp_q;

endmodule
